// File: rtl/vdec1_sym_pack.sv
// Soft-symbol packer: four 6-bit lanes per 24-bit DIRAM word, written from a programmable base.
// Optional input saturation to [-32,31] is enabled by defining VDEC1_SYM_PACK_SAT_EN.
module vdec1_sym_pack #(
    parameter int SYM_IN_W = 8,
    parameter int ADDR_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [7:0]          sym_num,
    input  logic                sym_vld,
    input  logic [SYM_IN_W-1:0] sym_data,
    output logic                sym_rdy,
    output logic                diram_wr_req,
    input  logic                diram_wr_ack,
    output logic [ADDR_W-1:0]   diram_waddr,
    output logic [23:0]         diram_wdata,
    output logic                busy,
    output logic                done,
    output logic [6:0]          word_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, FIN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  rem;
    logic [1:0]  lane;
    logic [23:0] pack, pack_nxt;
    logic [5:0]  lane_val;
    logic        accept, last_sym;

    assign accept   = sym_vld & sym_rdy;
    assign last_sym = (lane == 2'd3) || (rem == 8'd1);

`ifdef VDEC1_SYM_PACK_SAT_EN
    localparam logic signed [SYM_IN_W-1:0] SAT_MAX = SYM_IN_W'(31);
    localparam logic signed [SYM_IN_W-1:0] SAT_MIN = SYM_IN_W'(-32);

    always_comb begin
        if ($signed(sym_data) > SAT_MAX)
            lane_val = 6'h1F;
        else if ($signed(sym_data) < SAT_MIN)
            lane_val = 6'h20;
        else
            lane_val = sym_data[5:0];
    end
`else
    // Upstream guarantees in-range values, so the high bits carry only sign extension.
    logic sym_unused;
    assign sym_unused = ^sym_data;
    assign lane_val   = sym_data[5:0];
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        pack_nxt = pack;
        case (lane)
            2'd0:    pack_nxt[5:0]   = lane_val;
            2'd1:    pack_nxt[11:6]  = lane_val;
            2'd2:    pack_nxt[17:12] = lane_val;
            default: pack_nxt[23:18] = lane_val;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A start in any state aborts the current frame and reloads the parameters.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = (sym_num != 8'd0) ? FILL : FIN;
        end else begin
            case (state)
                FILL:    if (accept && last_sym) state_nxt = WRITE;
                WRITE:   if (diram_wr_ack) state_nxt = (rem != 8'd0) ? FILL : FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        sym_rdy      = (state == FILL);
        diram_wr_req = (state == WRITE);
        done         = (state == FIN);
        busy         = start | (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diram_waddr <= '0;
            diram_wdata <= '0;
            word_cnt    <= '0;
            rem         <= '0;
            lane        <= '0;
            pack        <= '0;
        end else if (start) begin
            diram_waddr <= base_addr;
            rem         <= sym_num;
            lane        <= '0;
            pack        <= '0;
            word_cnt    <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        pack <= pack_nxt;
                        lane <= lane + 2'd1;
                        rem  <= rem - 8'd1;
                        if (last_sym)
                            diram_wdata <= pack_nxt;
                    end
                end
                WRITE: begin
                    if (diram_wr_ack) begin
                        diram_waddr <= diram_waddr + ADDR_W'(1);
                        word_cnt    <= word_cnt + 7'd1;
                        pack        <= '0;
                        lane        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
